// File: rtl/data_bus_mem.sv
// Data-side bus for the pipeline MEM stage: word RAM plus a small
// peripheral block (reload timer with interrupt, LED register, free-running
// systick). Loads are combinational so the MEM stage sees data in-cycle;
// stores commit on the rising clock edge.
//
// Bus handshake: there is no valid/ready pair. i_mem_read / i_mem_write act
// as request strobes that are always accepted. A read returns data in the
// same cycle; a write commits at the next posedge. A simultaneous read and
// write to the same location returns the old value.
module data_bus_mem #(
  parameter int RAM_WORDS = 256
) (
  input  logic        reset,
  input  logic        clk,
  input  logic        i_mem_read,
  input  logic        i_mem_write,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic        o_irq,
  output logic [7:0]  o_leds
);

  localparam int AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;

  // Peripheral word addresses (byte address >> 2)
  localparam logic [29:0] TH_WADDR      = 30'h1000_0000;
  localparam logic [29:0] TL_WADDR      = 30'h1000_0001;
  localparam logic [29:0] TCON_WADDR    = 30'h1000_0002;
  localparam logic [29:0] LED_WADDR     = 30'h1000_0003;
  localparam logic [29:0] SYSTICK_WADDR = 30'h1000_0005;

  logic [31:0] ram [RAM_WORDS];
  logic [31:0] th_q;
  logic [31:0] tl_q;
  logic [2:0]  tcon_q;
  logic [7:0]  leds_q;
  logic [31:0] systick_q;

  logic [29:0]   waddr;
  logic [AW-1:0] ram_idx;
  logic          ram_hit;
  logic          wr_en;
  logic          th_wr;
  logic          tl_wr;
  logic          tcon_wr;
  logic          led_wr;
  logic          tl_max;
  logic          reload;
  logic          unused_addr_bits;

  // Address decode; byte-offset bits are irrelevant for word accesses
  assign waddr            = i_addr[31:2];
  assign ram_idx          = waddr[AW-1:0];
  assign ram_hit          = (waddr < 30'(RAM_WORDS));
  assign unused_addr_bits = ^i_addr[1:0];

  // Writes are blocked while reset is held
  assign wr_en   = i_mem_write & ~reset;
  assign th_wr   = wr_en & (waddr == TH_WADDR);
  assign tl_wr   = wr_en & (waddr == TL_WADDR);
  assign tcon_wr = wr_en & (waddr == TCON_WADDR);
  assign led_wr  = wr_en & (waddr == LED_WADDR);

  // Reload happens when the enabled counter sits at all-ones
  assign tl_max = (tl_q == 32'hFFFF_FFFF);
  assign reload = tcon_q[0] & tl_max;

  // RAM store; contents are deliberately not touched by reset
  always_ff @(posedge clk) begin
    if (wr_en && ram_hit) begin
      ram[ram_idx] <= i_wdata;
    end
  end

  // TH reload value and LED register: plain software registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      th_q   <= 32'h0;
      leds_q <= 8'h0;
    end else begin
      if (th_wr)  th_q   <= i_wdata;
      if (led_wr) leds_q <= i_wdata[7:0];
    end
  end

  // TL counter: software store wins, otherwise count and reload from TH
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tl_q <= 32'h0;
    end else if (tl_wr) begin
      tl_q <= i_wdata;
    end else if (tcon_q[0]) begin
      tl_q <= tl_max ? th_q : tl_q + 32'd1;
    end
  end

  // TCON: software store wins; a reload pre-empted by a TL store raises nothing
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tcon_q <= 3'b000;
    end else if (tcon_wr) begin
      tcon_q <= i_wdata[2:0];
    end else if (reload && tcon_q[1] && !tl_wr) begin
      tcon_q[2] <= 1'b1;
    end
  end

  // Free-running cycle counter, read-only from the bus
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      systick_q <= 32'h0;
    end else begin
      systick_q <= systick_q + 32'd1;
    end
  end

  // Combinational load mux; zero when idle, unmapped or in reset
  always_comb begin
    o_rdata = 32'h0;
    if (!reset && i_mem_read) begin
      if (ram_hit) begin
        o_rdata = ram[ram_idx];
      end else begin
        case (waddr)
          TH_WADDR:      o_rdata = th_q;
          TL_WADDR:      o_rdata = tl_q;
          TCON_WADDR:    o_rdata = {29'h0, tcon_q};
          LED_WADDR:     o_rdata = {24'h0, leds_q};
          SYSTICK_WADDR: o_rdata = systick_q;
          default:       o_rdata = 32'h0;
        endcase
      end
    end
  end

  assign o_irq  = tcon_q[1] & tcon_q[2];
  assign o_leds = leds_q;

endmodule

// File: doc/data_bus_mem.md
DATA_BUS_MEM -- requirements
Module: data_bus_mem

Interface
REQ-001 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on posedge.
REQ-003 SHALL have port i_mem_read, input, 1 bit: load request from the EX/MEM latch.
REQ-004 SHALL have port i_mem_write, input, 1 bit: store request from the EX/MEM latch.
REQ-005 SHALL have port i_addr, input, 32 bits: byte address (ALU result); bits [1:0] ignored.
REQ-006 SHALL have port i_wdata, input, 32 bits: store data (rt value).
REQ-007 SHALL have port o_rdata, output, 32 bits: load data to MEM/WB, combinational.
REQ-008 SHALL have port o_irq, output, 1 bit: timer interrupt request to the PC/control unit.
REQ-009 SHALL have port o_leds, output, 8 bits: LED register.
REQ-010 SHALL use parameter RAM_WORDS, default 256: data RAM depth in words.

Function
REQ-011 SHALL decode RAM at 0x00000000 to 0x000003FC, word index i_addr[9:2], for RAM_WORDS=256.
REQ-012 SHALL decode peripherals: 0x40000000 TH (reload, R/W); 0x40000004 TL (counter, R/W); 0x40000008 TCON (R/W, bits [2:0], upper bits read 0); 0x4000000C LEDs (R/W, bits [7:0]); 0x40000014 SYSTICK (read-only).
REQ-013 SHALL write RAM or the target register on the posedge where i_mem_write=1 and the address is mapped.
REQ-014 SHALL ignore writes to unmapped addresses and to SYSTICK.
REQ-015 SHALL drive o_rdata combinationally from the addressed word when i_mem_read=1; this gives zero-latency read within the MEM cycle.
REQ-016 SHALL drive o_rdata=0 when i_mem_read=0 or the address is unmapped.
REQ-017 SHALL treat i_mem_read=1 and i_mem_write=1 in the same cycle as follows: o_rdata returns the pre-write value and the write commits at the edge.
REQ-018 SHALL use TCON bit0 as timer enable, bit1 as interrupt enable and bit2 as interrupt status.
REQ-019 SHALL, when TCON[0]=1, increment TL by 1 each cycle.
REQ-020 SHALL, when TCON[0]=1 and TL=0xFFFFFFFF, load TL<=TH instead of wrapping to 0.
REQ-021 SHALL, on that reload, set TCON[2]<=1 if TCON[1]=1; TCON[2] is left unchanged otherwise.
REQ-022 SHALL hold TL and TCON[2] unchanged when TCON[0]=0.
REQ-023 SHALL give a software write to TL or TCON priority over the timer update in the same cycle; the written value is taken whole.
REQ-024 SHALL drive o_irq = TCON[1] & TCON[2], registered-state derived, with no extra latency.
REQ-025 SHALL keep TCON[2] set until software writes it to 0.
REQ-026 SHALL increment SYSTICK every cycle unconditionally and wrap 0xFFFFFFFF to 0.
REQ-027 SHALL drive o_leds directly from the LED register.

Reset
REQ-028 SHALL, on reset=1 and asynchronously, clear TH, TL, TCON, LEDs and SYSTICK to 0.
REQ-029 SHALL force o_irq=0 and o_leds=0 while reset=1, and o_rdata=0 while reset=1.
REQ-030 SHALL leave RAM contents unchanged by reset.
REQ-031 SHALL suppress writes while reset=1.
REQ-032 SHALL, on reset assertion mid-count, clear TL and TCON immediately, with no pending interrupt surviving.

Verification
REQ-033 Store 0xDEADBEEF to 0x00000010, then load 0x00000010 on the next cycle: o_rdata=0xDEADBEEF. Load 0x00000020 (never written after a known write of 0): o_rdata=0.
REQ-034 Write TH=0xFFFFFFFC, TL=0xFFFFFFFE, TCON=0x3. TL reaches 0xFFFFFFFF after 1 cycle, then 0xFFFFFFFC. TCON reads 0x7 and o_irq=1 on the cycle after reload. Write TCON=0x3: o_irq=0.
REQ-035 Same set-up with TCON=0x1: reload occurs, TCON stays 0x1 and o_irq stays 0.
REQ-036 In the reload cycle (TL=0xFFFFFFFF), store TL=0x5: TL=0x5 next cycle and TCON[2] is not set.
REQ-037 Store 0xA5 to 0x4000000C: o_leds=0xA5. Store to 0x50000000 then load 0x50000000: o_rdata=0 and no state changes.
REQ-038 Assert reset asynchronously with o_irq=1 and TL counting: o_irq, o_leds and TL go to 0 before the next clk edge, and RAM word 0x10 still reads 0xDEADBEEF after release.
